width_sched: RTL and testbench

WIDTH_SCHED -- requirements
Module: width_sched

---
 rtl/width_sched.sv | 108 ++++++++++
 tb/tb_width_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/width_sched.sv
// Two-port request scheduler for a shared combinational widthcb instance.
// Optional round-robin arbitration on simultaneous requests: define WIDTH_SCHED_RR_EN.
//
// state | meaning
// IDLE  | waiting for req0/req1; arbitration happens here
// ISSUE | wcb_y presented to widthcb, winner's gnt high
// HOLD  | rsp_valid high, response held until rsp_ready

`ifndef WIDTHCB_WIDTH
`define WIDTHCB_WIDTH 16
`endif

module width_sched #(
    parameter int W = `WIDTHCB_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [7:0]   y0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [7:0]   y1,
    output logic         gnt1,
    output logic [7:0]   wcb_y,
    input  logic [W-1:0] wcb_out,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_width,
    input  logic         rsp_ready,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0] state;
    logic       win_id;

`ifdef WIDTH_SCHED_RR_EN
    logic last_win;

    // On a tie the port that lost the previous grant wins.
    always_comb begin
        win_id = ~req0;
        if (req0 && req1)
            win_id = ~last_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_win <= 1'b1;
        else if (state == IDLE && (req0 || req1))
            last_win <= win_id;
    end
`else
    // Fixed priority: port 0 wins any tie.
    always_comb begin
        win_id = ~req0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            wcb_y     <= 8'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_width <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state  <= ISSUE;
                        wcb_y  <= win_id ? y1 : y0;
                        rsp_id <= win_id;
                        gnt0   <= ~win_id;
                        gnt1   <= win_id;
                    end
                end
                ISSUE: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    rsp_width <= wcb_out;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_width_sched.sv
// Directed-vector bench for width_sched; widthcb modelled as width = 5*Y + 3.
// Expectations follow WIDTH_SCHED_RR_EN when the bench is built with it defined.

module tb_width_sched;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [7:0]   y0 = 8'd0, y1 = 8'd0;
    logic         gnt0, gnt1;
    logic [7:0]   wcb_y;
    logic [W-1:0] wcb_out;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_width;
    logic         rsp_ready = 1'b1;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External widthcb model
    assign wcb_out = {8'd0, wcb_y} * 16'd5 + 16'd3;

    width_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .y0(y0), .gnt0(gnt0),
        .req1(req1), .y1(y1), .gnt1(gnt1),
        .wcb_y(wcb_y), .wcb_out(wcb_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_width(rsp_width),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  yy0;
        logic [7:0]  yy1;
        logic        exp_id;
        logic [15:0] exp_w;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'd100, 8'd0,   1'b0, 16'd503};
        vecs[1] = '{1'b0, 1'b1, 8'd0,   8'd255, 1'b1, 16'd1278};
        vecs[2] = '{1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 16'd3};
        vecs[3] = '{1'b1, 1'b0, 8'd255, 8'd0,   1'b0, 16'd1278};
`ifdef WIDTH_SCHED_RR_EN
        vecs[4] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b1, 16'd1153};
        vecs[5] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b0, 16'd103};
        vecs[6] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b1, 16'd1153};
`else
        vecs[4] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b0, 16'd103};
        vecs[5] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b0, 16'd103};
        vecs[6] = '{1'b1, 1'b1, 8'd20,  8'd230, 1'b0, 16'd103};
`endif
        vecs[7] = '{1'b0, 1'b1, 8'd0,   8'd20,  1'b1, 16'd103};

        #12;
        check("reset gnt0", gnt0, 0);
        check("reset gnt1", gnt1, 0);
        check("reset valid", rsp_valid, 0);
        check("reset width", rsp_width, 0);
        check("reset wcb_y", wcb_y, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        tick;
        tick;
        check("idle no req busy", busy, 0);
        check("idle no req valid", rsp_valid, 0);

        // Table-driven transactions, rsp_ready high: one response per three cycles
        for (int i = 0; i < 8; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1;
            y0 = vecs[i].yy0;  y1 = vecs[i].yy1;
            rsp_ready = 1'b1;
            tick;
            check($sformatf("v%0d gnt0", i), gnt0, {31'd0, ~vecs[i].exp_id});
            check($sformatf("v%0d gnt1", i), gnt1, {31'd0, vecs[i].exp_id});
            check($sformatf("v%0d valid early", i), rsp_valid, 0);
            check($sformatf("v%0d busy issue", i), busy, 1);
            if (vecs[i].exp_id) req1 = 1'b0; else req0 = 1'b0;
            tick;
            check($sformatf("v%0d valid", i), rsp_valid, 1);
            check($sformatf("v%0d id", i), rsp_id, {31'd0, vecs[i].exp_id});
            check($sformatf("v%0d width", i), rsp_width, {16'd0, vecs[i].exp_w});
            check($sformatf("v%0d gnt off", i), gnt0 | gnt1, 0);
            check($sformatf("v%0d busy hold", i), busy, 1);
            tick;
            check($sformatf("v%0d valid clr", i), rsp_valid, 0);
            check($sformatf("v%0d busy idle", i), busy, 0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;

        // Backpressure: response held while rsp_ready low, competing request not granted
        rsp_ready = 1'b0;
        req1 = 1'b1; y1 = 8'd255;
        tick;
        check("bp gnt1", gnt1, 1);
        req1 = 1'b0;
        req0 = 1'b1; y0 = 8'd100;
        tick;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp valid c%0d", c), rsp_valid, 1);
            check($sformatf("bp id c%0d", c), rsp_id, 1);
            check($sformatf("bp width c%0d", c), rsp_width, 1278);
            check($sformatf("bp no gnt c%0d", c), gnt0 | gnt1, 0);
            tick;
        end
        rsp_ready = 1'b1;
        #2;
        check("bp valid before ready edge", rsp_valid, 1);
        tick;
        check("bp valid clr", rsp_valid, 0);
        tick;
        check("bp pending gnt0", gnt0, 1);
        req0 = 1'b0;
        tick;
        check("bp pending width", rsp_width, 503);
        check("bp pending id", rsp_id, 0);
        tick;

        // Reset during HOLD discards the response
        rsp_ready = 1'b0;
        req0 = 1'b1; y0 = 8'd20;
        tick;
        req0 = 1'b0;
        tick;
        check("rst pre valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst valid", rsp_valid, 0);
        check("rst width", rsp_width, 0);
        check("rst wcb_y", wcb_y, 0);
        check("rst busy", busy, 0);
        check("rst gnt", gnt0 | gnt1, 0);
        tick;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            check($sformatf("post rst valid c%0d", c), rsp_valid, 0);
            check($sformatf("post rst gnt c%0d", c), gnt0 | gnt1, 0);
            check($sformatf("post rst busy c%0d", c), busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (rst_n && gnt0 && gnt1) begin
            n_checks++;
            n_fail++;
            $display("FAIL gnt exclusive: gnt0=%0d gnt1=%0d required not both 1", gnt0, gnt1);
        end
    end

endmodule
